// File: rtl/rtc_pkg.sv
// Shared BCD time/date helpers: field limits, validity check and BCD increment.
// The downstream date bank imports this package as well.
package rtc_pkg;

    localparam logic [7:0] SEG_MAX     = 8'h59;
    localparam logic [7:0] MIN_MAX     = 8'h59;
    localparam logic [7:0] HORA_MAX_24 = 8'h23;

    // Packed BCD comparison is numeric once both nibbles are known to be <= 9.
    function automatic logic bcd_valido(input logic [7:0] valor, input logic [7:0] max);
        return (valor[7:4] <= 4'd9) && (valor[3:0] <= 4'd9) && (valor <= max);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] valor);
        if (valor[3:0] >= 4'd9)
            return {valor[7:4] + 4'd1, 4'h0};
        return {valor[7:4], valor[3:0] + 4'd1};
    endfunction

endpackage

// File: rtl/contador_bcd_campo.sv
// One packed-BCD time field: validated load from the bus, or increment with
// wrap to 00 at MAX. Carry out is combinational so the chain ripples in one cycle.
module contador_bcd_campo
    import rtc_pkg::*;
#(
    parameter logic [7:0] MAX = SEG_MAX
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       load_n,
    input  logic [7:0] dato,
    output logic [7:0] valor,
    output logic       carry,
    output logic       rechazo
);

    logic dato_ok;
    logic tope;

    // An out-of-range field is treated like MAX: the next increment forces 00 with carry.
    always_comb begin
        dato_ok = bcd_valido(dato, MAX);
        tope    = !bcd_valido(valor, MAX) || (valor == MAX);
    end

    assign carry = inc && load_n && tope;

    always_ff @(posedge clk) begin
        if (reset) begin
            valor   <= '0;
            rechazo <= 1'b0;
        end else begin
            rechazo <= !load_n && !dato_ok;
            if (!load_n) begin
                if (dato_ok)
                    valor <= dato;
            end else if (inc) begin
                valor <= tope ? '0 : bcd_inc(valor);
            end
        end
    end

endmodule

// File: rtl/banco_registros_hora.sv
// Time-of-day register bank: seconds/minutes/hours in BCD, advanced by a 1 Hz tick,
// loaded from the PicoBlaze bus on active-low hold strobes; emits a day-carry pulse.
module banco_registros_hora
    import rtc_pkg::*;
#(
    parameter logic [7:0] HORA_MAX = HORA_MAX_24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic [7:0] out_port,
    input  logic       hold_seg_hora,
    input  logic       hold_min_hora,
    input  logic       hold_hora_hora,
    output logic [7:0] seg_hora,
    output logic [7:0] min_hora,
    output logic [7:0] hora_hora,
    output logic       carry_dia,
    output logic       error_carga
);

    logic carry_seg, carry_min, carry_hora;
    logic rech_seg, rech_min, rech_hora;
    logic inc_min, inc_hora;

    // A field under load swallows any incoming carry.
    assign inc_min  = carry_seg & hold_min_hora;
    assign inc_hora = carry_min & hold_hora_hora;

    contador_bcd_campo #(.MAX(SEG_MAX)) u_seg (
        .clk     (clk),
        .reset   (reset),
        .inc     (tick_1hz),
        .load_n  (hold_seg_hora),
        .dato    (out_port),
        .valor   (seg_hora),
        .carry   (carry_seg),
        .rechazo (rech_seg)
    );

    contador_bcd_campo #(.MAX(MIN_MAX)) u_min (
        .clk     (clk),
        .reset   (reset),
        .inc     (inc_min),
        .load_n  (hold_min_hora),
        .dato    (out_port),
        .valor   (min_hora),
        .carry   (carry_min),
        .rechazo (rech_min)
    );

    contador_bcd_campo #(.MAX(HORA_MAX)) u_hora (
        .clk     (clk),
        .reset   (reset),
        .inc     (inc_hora),
        .load_n  (hold_hora_hora),
        .dato    (out_port),
        .valor   (hora_hora),
        .carry   (carry_hora),
        .rechazo (rech_hora)
    );

    assign error_carga = rech_seg | rech_min | rech_hora;

    always_ff @(posedge clk) begin
        if (reset)
            carry_dia <= 1'b0;
        else
            carry_dia <= carry_hora;
    end

endmodule

// File: tb/tb_banco_registros_hora.sv
// Directed and randomized checks of banco_registros_hora against a decimal-integer
// model of the clock (fields kept as plain 0..59 / 0..23 numbers).
module tb_banco_registros_hora;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_1hz;
    logic [7:0] out_port;
    logic       hold_seg_hora, hold_min_hora, hold_hora_hora;
    logic [7:0] seg_hora, min_hora, hora_hora;
    logic       carry_dia, error_carga;

    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    int m_s, m_m, m_h;
    bit m_cd, m_err;

    banco_registros_hora #(.HORA_MAX(8'h23)) dut (
        .clk            (clk),
        .reset          (reset),
        .tick_1hz       (tick_1hz),
        .out_port       (out_port),
        .hold_seg_hora  (hold_seg_hora),
        .hold_min_hora  (hold_min_hora),
        .hold_hora_hora (hold_hora_hora),
        .seg_hora       (seg_hora),
        .min_hora       (min_hora),
        .hora_hora      (hora_hora),
        .carry_dia      (carry_dia),
        .error_carga    (error_carga)
    );

    always #5 clk = ~clk;

    function automatic int dec_of(input logic [7:0] b);
        if (b[7:4] > 4'd9 || b[3:0] > 4'd9)
            return -1;
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] to_bcd(input int n);
        logic [7:0] r;
        r[7:4] = 4'(n / 10);
        r[3:0] = 4'(n % 10);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, advance the model, then sample 1 ns after the edge.
    task automatic step(input bit rst, input bit tk, input bit ls, input bit lm,
                        input bit lh, input logic [7:0] d);
        int  dv;
        bit  bad_s, bad_m, bad_h, cs, cm, ch;
        reset          = rst;
        tick_1hz       = tk;
        hold_seg_hora  = !ls;
        hold_min_hora  = !lm;
        hold_hora_hora = !lh;
        out_port       = d;
        if (rst) begin
            m_s = 0; m_m = 0; m_h = 0; m_cd = 0; m_err = 0;
        end else begin
            dv    = dec_of(d);
            bad_s = ls && !(dv >= 0 && dv <= 59);
            bad_m = lm && !(dv >= 0 && dv <= 59);
            bad_h = lh && !(dv >= 0 && dv <= 23);
            m_err = bad_s || bad_m || bad_h;
            cs = tk && !ls && (m_s == 59);
            if (ls) begin
                if (!bad_s) m_s = dv;
            end else if (tk) m_s = (m_s + 1) % 60;
            cm = cs && !lm && (m_m == 59);
            if (lm) begin
                if (!bad_m) m_m = dv;
            end else if (cs) m_m = (m_m + 1) % 60;
            ch = cm && !lh && (m_h == 23);
            if (lh) begin
                if (!bad_h) m_h = dv;
            end else if (cm) m_h = (m_h + 1) % 24;
            m_cd = ch;
        end
        @(posedge clk);
        #1;
        chk("seg_hora", seg_hora, to_bcd(m_s));
        chk("min_hora", min_hora, to_bcd(m_m));
        chk("hora_hora", hora_hora, to_bcd(m_h));
        chk("carry_dia", {7'b0, carry_dia}, {7'b0, m_cd});
        chk("error_carga", {7'b0, error_carga}, {7'b0, m_err});
    endtask

    task automatic preload(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        step(0, 0, 0, 0, 1, h);
        step(0, 0, 0, 1, 0, m);
        step(0, 0, 1, 0, 0, s);
    endtask

    initial begin
        reset = 1'b1; tick_1hz = 1'b0; out_port = '0;
        hold_seg_hora = 1'b1; hold_min_hora = 1'b1; hold_hora_hora = 1'b1;

        // Reset during an active seconds load
        step(1, 0, 1, 0, 0, 8'h45);
        chk("reset_seg", seg_hora, 8'h00);
        chk("reset_err", {7'b0, error_carga}, 8'h00);

        // Accepted minutes load
        step(0, 0, 0, 1, 0, 8'h37);
        chk("load_min", min_hora, 8'h37);

        // Rejected hour loads, one error pulse each
        step(0, 0, 0, 0, 1, 8'h24);
        chk("rej24_err", {7'b0, error_carga}, 8'h01);
        step(0, 0, 0, 0, 1, 8'h1A);
        chk("rej1A_err", {7'b0, error_carga}, 8'h01);
        chk("rej_hora", hora_hora, 8'h00);
        step(0, 0, 0, 0, 0, 8'h00);

        // Full wrap and day carry
        preload(8'h23, 8'h59, 8'h59);
        step(0, 1, 0, 0, 0, 8'h00);
        chk("wrap_carry", {7'b0, carry_dia}, 8'h01);
        chk("wrap_hora", hora_hora, 8'h00);
        step(0, 0, 0, 0, 0, 8'h00);
        chk("carry_one_cycle", {7'b0, carry_dia}, 8'h00);

        // 09->10 and 19->20
        step(0, 0, 1, 0, 0, 8'h09);
        step(0, 1, 0, 0, 0, 8'h00);
        chk("roll_09", seg_hora, 8'h10);
        step(0, 0, 1, 0, 0, 8'h19);
        step(0, 1, 0, 0, 0, 8'h00);
        chk("roll_19", seg_hora, 8'h20);

        // Load-and-tick collision
        preload(8'h12, 8'h34, 8'h59);
        step(0, 1, 0, 1, 0, 8'h10);
        chk("coll_seg", seg_hora, 8'h00);
        chk("coll_min", min_hora, 8'h10);
        chk("coll_hora", hora_hora, 8'h12);

        // Multi-cycle hold on seconds
        for (int i = 0; i < 3; i++)
            step(0, 1, 1, 0, 0, 8'h05);
        chk("hold_seg", seg_hora, 8'h05);
        chk("hold_min", min_hora, 8'h10);
        step(0, 1, 0, 0, 0, 8'h00);
        chk("release_seg", seg_hora, 8'h06);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [7:0] d;
            int         k;
            if ($urandom_range(0, 24) == 0)
                preload(8'h23, 8'h59, 8'(8'h55 + $urandom_range(0, 4)));
            k = int'($urandom_range(0, 59));
            d = ($urandom_range(0, 1) == 0) ? to_bcd(k) : 8'($urandom);
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0,
                 d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
